// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: generic pipeline stage register with valid/ready handshake.
// Carries an opaque payload, a vector of active-low write enables and a flush
// marker between two pipeline stages. Supports stall/interlock hold (with
// write-enable squash), synchronous kill (bubble insertion) and an optional
// skid entry.
//
// Build option: define PIPE_SKID_EN to add one skid entry. in_ready then comes
// from a flop, so there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 hold stage contents, accept nothing
//   kill                  squash stage contents (redirect)
//   in_valid/in_ready     upstream handshake
//   in_data/in_wen_n      upstream payload and active-low write enables
//   in_flush              upstream flush marker
//   out_valid/out_ready   downstream handshake
//   out_data/out_wen_n    registered payload and write enables (all-1 = no write)
//   out_flush             registered flush marker
module pipe_stage_regs #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned WEN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              kill,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WEN_W-1:0]  in_wen_n,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WEN_W-1:0]  out_wen_n,
  output logic              out_flush
);

  localparam logic [WEN_W-1:0] WenNone = {WEN_W{1'b1}};

  logic [DATA_W-1:0] data_q;
  logic [WEN_W-1:0]  wen_n_q;
  logic              flush_q;
  logic              valid_q;
  logic              load;

  assign out_data  = data_q;
  assign out_wen_n = wen_n_q;
  assign out_flush = flush_q;
  assign out_valid = valid_q;
  assign load      = in_valid && in_ready;

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [WEN_W-1:0]  skid_wen_n_q;
  logic              skid_flush_q;
  logic              ready_q;

  // ready_q tracks "not full after this edge"; stall/kill gate it at the port.
  assign in_ready = ready_q && !stall && !kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      valid_q      <= 1'b0;
      data_q       <= '0;
      wen_n_q      <= WenNone;
      flush_q      <= 1'b0;
      skid_data_q  <= '0;
      skid_wen_n_q <= WenNone;
      skid_flush_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (kill) begin
      state_q      <= StEmpty;
      valid_q      <= 1'b0;
      wen_n_q      <= WenNone;
      flush_q      <= 1'b0;
      skid_wen_n_q <= WenNone;
      skid_flush_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (stall) begin
      // Only the presented entry is squashed; the skid keeps its enables.
      wen_n_q <= WenNone;
    end else begin
      case (state_q)
        StEmpty: begin
          if (load) begin
            data_q  <= in_data;
            wen_n_q <= in_wen_n;
            flush_q <= in_flush;
            valid_q <= 1'b1;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (load && out_ready) begin
            data_q  <= in_data;
            wen_n_q <= in_wen_n;
            flush_q <= in_flush;
          end else if (load) begin
            skid_data_q  <= in_data;
            skid_wen_n_q <= in_wen_n;
            skid_flush_q <= in_flush;
            state_q      <= StFull;
            ready_q      <= 1'b0;
          end else if (out_ready) begin
            valid_q <= 1'b0;
            wen_n_q <= WenNone;
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (out_ready) begin
            data_q       <= skid_data_q;
            wen_n_q      <= skid_wen_n_q;
            flush_q      <= skid_flush_q;
            skid_wen_n_q <= WenNone;
            skid_flush_q <= 1'b0;
            state_q      <= StOne;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= StEmpty;
          valid_q <= 1'b0;
          wen_n_q <= WenNone;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`else

  // Accept when the slot is empty or is being drained this cycle.
  assign in_ready = !stall && !kill && (!valid_q || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      wen_n_q <= WenNone;
      flush_q <= 1'b0;
    end else if (kill) begin
      valid_q <= 1'b0;
      wen_n_q <= WenNone;
      flush_q <= 1'b0;
    end else if (stall) begin
      // Squash so hazard logic does not keep re-detecting the held entry.
      wen_n_q <= WenNone;
    end else if (load) begin
      data_q  <= in_data;
      wen_n_q <= in_wen_n;
      flush_q <= in_flush;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
      wen_n_q <= WenNone;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;

  localparam int unsigned DW = 160;
  localparam int unsigned WW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, kill;
  logic          in_valid, in_ready, in_flush;
  logic          out_valid, out_ready, out_flush;
  logic [DW-1:0] in_data, out_data;
  logic [WW-1:0] in_wen_n, out_wen_n;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipe_stage_regs #(.DATA_W(DW), .WEN_W(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_wen_n  (in_wen_n),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_wen_n (out_wen_n),
    .out_flush (out_flush)
  );

  // Reference model: the stage is a queue of entries (capacity 1, or 2 with skid).
  typedef struct packed {
    logic [DW-1:0] data;
    logic [WW-1:0] wen_n;
    logic          flush;
  } entry_t;

  entry_t        mq[$];
  logic          m_squash;
  logic [DW-1:0] m_data;
  logic          m_flush;

  function automatic logic m_ready();
`ifdef PIPE_SKID_EN
    return (mq.size() < 2) && !stall && !kill;
`else
    return !stall && !kill && (mq.size() == 0 || out_ready);
`endif
  endfunction

  task automatic m_reset();
    mq.delete();
    m_squash = 1'b0;
    m_data   = '0;
    m_flush  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_edge();
    logic   acc, popped, fresh;
    entry_t e;
    acc = in_valid && m_ready();
    if (kill) begin
      mq.delete();
      m_flush = 1'b0;
    end else if (stall) begin
      m_squash = 1'b1;
    end else begin
      fresh  = (mq.size() == 0);
      popped = (mq.size() > 0) && out_ready;
      if (popped) void'(mq.pop_front());
      if (acc) begin
        e.data  = in_data;
        e.wen_n = in_wen_n;
        e.flush = in_flush;
        mq.push_back(e);
      end
      if ((popped || (fresh && acc)) && mq.size() > 0) begin
        m_squash = 1'b0;
        m_data   = mq[0].data;
        m_flush  = mq[0].flush;
      end
    end
  endtask

  task automatic idle();
    stall     = 1'b0;
    kill      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_wen_n  = '1;
    in_flush  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 'h55; in_wen_n = 2'b00; in_flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL reset_preload valid: got %b want 1", out_valid);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset valid: got %b want 0", out_valid);
    else passes++;
    checks++; if (out_data !== '0) $display("FAIL reset data: got %0h want 0", out_data);
    else passes++;
    checks++; if (out_wen_n !== 2'b11) $display("FAIL reset wen_n: got %b want 11", out_wen_n);
    else passes++;
    checks++; if (out_flush !== 1'b0) $display("FAIL reset flush: got %b want 0", out_flush);
    else passes++;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready);
    else passes++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = DW'(k); in_wen_n = 2'b01; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL stream in_ready[%0d]: got %b want 1", k, in_ready);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(k))
        $display("FAIL stream out[%0d]: got v=%b d=%0h want v=1 d=%0h", k, out_valid, out_data, k);
      else passes++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL stream drain valid: got %b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 'hA5; in_wen_n = 2'b00; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_wen_n !== 2'b00) $display("FAIL stall load wen_n: got %b want 00", out_wen_n);
    else passes++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall = 1'b1; in_valid = 1'b1; in_data = 'h5A; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL stall in_ready[%0d]: got %b want 0", c, in_ready);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'('hA5) || out_wen_n !== 2'b11)
        $display("FAIL stall hold[%0d]: got v=%b d=%0h w=%b want v=1 d=a5 w=11",
                 c, out_valid, out_data, out_wen_n);
      else passes++;
    end
    @(negedge clk);
    stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL stall release valid: got %b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_kill();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 'h44; in_wen_n = 2'b00;
    @(posedge clk);
    @(negedge clk);
    stall = 1'b1; kill = 1'b1; in_valid = 1'b1; in_data = 'h33; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL kill in_ready: got %b want 0", in_ready);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_wen_n !== 2'b11 || out_data !== DW'('h44))
      $display("FAIL kill out: got v=%b w=%b d=%0h want v=0 w=11 d=44", out_valid, out_wen_n, out_data);
    else passes++;
    @(negedge clk);
    idle();
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== DW'('h44))
      $display("FAIL kill after: got v=%b d=%0h want v=0 d=44", out_valid, out_data);
    else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 'h10; in_wen_n = 2'b10;
    @(posedge clk);
    @(negedge clk);
    in_data = 'h11; out_ready = 1'b0;
    #1;
`ifdef PIPE_SKID_EN
    checks++; if (in_ready !== 1'b1) $display("FAIL bp skid accept: got %b want 1", in_ready);
    else passes++;
    @(posedge clk); #1;
    checks++; if (out_data !== DW'('h10)) $display("FAIL bp head: got %0h want 10", out_data);
    else passes++;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp full in_ready: got %b want 0", in_ready);
    else passes++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'('h11))
      $display("FAIL bp second: got v=%b d=%0h want v=1 d=11", out_valid, out_data);
    else passes++;
`else
    checks++; if (in_ready !== 1'b0) $display("FAIL bp in_ready: got %b want 0", in_ready);
    else passes++;
    @(posedge clk); #1;
    checks++; if (out_data !== DW'('h10)) $display("FAIL bp head: got %0h want 10", out_data);
    else passes++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp ready: got %b want 1", in_ready);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'('h11))
      $display("FAIL bp second: got v=%b d=%0h want v=1 d=11", out_valid, out_data);
    else passes++;
    @(negedge clk);
    in_valid = 1'b0;
`endif
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp drained: got %b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 'h7; in_flush = 1'b1; in_wen_n = 2'b10;
    @(posedge clk); #1;
    checks++;
    if (out_flush !== 1'b1 || out_data !== DW'('h7))
      $display("FAIL flush load: got f=%b d=%0h want f=1 d=7", out_flush, out_data);
    else passes++;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_flush !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL flush kill: got f=%b v=%b want f=0 v=0", out_flush, out_valid);
    else passes++;
  endtask

  task automatic test_random();
    logic          exp_rdy;
    logic [WW-1:0] exp_wen;
    do_reset();
    m_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      stall     = ($urandom_range(0, 9) == 0);
      kill      = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_wen_n  = WW'($urandom_range(0, 3));
      in_flush  = ($urandom_range(0, 7) == 0);
      #1;
      exp_rdy = m_ready();
      checks++;
      if (in_ready !== exp_rdy) $display("FAIL rand in_ready[%0d]: got %b want %b", i, in_ready, exp_rdy);
      else passes++;
      m_edge();
      @(posedge clk); #1;
      exp_wen = '1;
      if (mq.size() > 0 && !m_squash) exp_wen = mq[0].wen_n;
      checks++;
      if (out_valid !== (mq.size() > 0) || out_wen_n !== exp_wen || out_flush !== m_flush)
        $display("FAIL rand ctl[%0d]: got v=%b w=%b f=%b want v=%b w=%b f=%b", i, out_valid,
                 out_wen_n, out_flush, (mq.size() > 0), exp_wen, m_flush);
      else passes++;
      checks++;
      if (out_data !== m_data) $display("FAIL rand data[%0d]: got %0h want %0h", i, out_data, m_data);
      else passes++;
      checks++;
      if (!out_valid && out_wen_n !== 2'b11)
        $display("FAIL rand invariant[%0d]: got w=%b want 11 when idle", i, out_wen_n);
      else passes++;
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_kill();
    test_backpressure();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
